// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// requester IDs and the clogb2 width helper used for address/counter sizing.
package dmem_arbiter_pkg;

  // Arbiter FSM states: ARB = normal round-robin, LOCK = m1 burst in progress
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Requester identifiers held in last_gnt
  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  // Number of bits needed to represent 'value' (minimum of 1)
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 32'sd0;
    for (int i = 0; i < 32; i++) begin
      if (v > 32'sd0) begin
        r = r + 32'sd1;
        v = v >> 1;
      end else begin
        r = r;
      end
    end
    if (r == 32'sd0) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the single
// synchronous RAM port. 'slave' is the arbiter view, 'master' the environment.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = clogb2(512 - 1)
);
  // Core requester (m0)
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [31:0]       m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;

  // Host requester (m1), with burst lock
  logic              m1_req_i;
  logic              m1_we_i;
  logic              m1_lock_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [31:0]       m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;

  // Shared read data
  logic [31:0]       rdata_o;

  // RAM port
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_wdata_i,
    input  ram_rdata_i,
    output m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o, rdata_o,
    output ram_addr_o, ram_we_o, ram_wdata_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_lock_i, m1_addr_i, m1_wdata_i,
    output ram_rdata_i,
    input  m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o, rdata_o,
    input  ram_addr_o, ram_we_o, ram_wdata_o
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data RAM.
// m0 (core) and m1 (host) share the port round-robin; m1 may lock the port
// for a burst of up to BURST_MAX beats. Grants are combinational, read-valid
// is a one-cycle registered pipeline tracking the previous cycle's grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RAM_DEPTH = 512,
  parameter int BURST_MAX = 16
) (
  input logic          clk,
  input logic          reset_i,
  dmem_arbiter_if.slave bus
);

  localparam int ADDR_W = clogb2(RAM_DEPTH - 1);
  localparam int CNT_W  = clogb2(BURST_MAX);

  arb_state_e        state;
  logic              last_gnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              rvalid_m0;
  logic              rvalid_m1;

  logic              gnt_m0;
  logic              gnt_m1;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [31:0]       sel_wdata;

  assign cnt_inc = burst_cnt + CNT_W'(1);

  // Grant decision: round-robin in ARB, m1 only while a burst is locked
  always_comb begin
    gnt_m0 = 1'b0;
    gnt_m1 = 1'b0;
    if (reset_i) begin
      gnt_m0 = 1'b0;
      gnt_m1 = 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (bus.m0_req_i && bus.m1_req_i) begin
            if (last_gnt == ID_M0) begin
              gnt_m1 = 1'b1;
            end else begin
              gnt_m0 = 1'b1;
            end
          end else if (bus.m0_req_i) begin
            gnt_m0 = 1'b1;
          end else if (bus.m1_req_i) begin
            gnt_m1 = 1'b1;
          end else begin
            gnt_m0 = 1'b0;
            gnt_m1 = 1'b0;
          end
        end
        LOCK: begin
          gnt_m1 = bus.m1_req_i;
        end
        default: begin
          gnt_m0 = 1'b0;
          gnt_m1 = 1'b0;
        end
      endcase
    end
  end

  // RAM port mux: granted requester drives the port, otherwise all zeros
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = 32'h0000_0000;
    if (gnt_m0) begin
      sel_addr  = bus.m0_addr_i;
      sel_we    = bus.m0_we_i;
      sel_wdata = bus.m0_wdata_i;
    end else if (gnt_m1) begin
      sel_addr  = bus.m1_addr_i;
      sel_we    = bus.m1_we_i;
      sel_wdata = bus.m1_wdata_i;
    end else begin
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_wdata = 32'h0000_0000;
    end
  end

  assign bus.ram_addr_o  = sel_addr;
  assign bus.ram_we_o    = sel_we;
  assign bus.ram_wdata_o = sel_wdata;
  assign bus.m0_gnt_o    = gnt_m0;
  assign bus.m1_gnt_o    = gnt_m1;

  // Read-valid is masked during reset so a read in flight never surfaces
  assign bus.m0_rvalid_o = rvalid_m0 & ~reset_i;
  assign bus.m1_rvalid_o = rvalid_m1 & ~reset_i;
  assign bus.rdata_o     = ((rvalid_m0 | rvalid_m1) & ~reset_i) ? bus.ram_rdata_i
                                                                 : 32'h0000_0000;

  // FSM, fairness pointer, burst counter and read-valid pipeline
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state     <= ARB;
      last_gnt  <= ID_M1;
      burst_cnt <= '0;
      rvalid_m0 <= 1'b0;
      rvalid_m1 <= 1'b0;
    end else begin
      rvalid_m0 <= gnt_m0 & ~bus.m0_we_i;
      rvalid_m1 <= gnt_m1 & ~bus.m1_we_i;
      case (state)
        ARB: begin
          if (gnt_m0) begin
            last_gnt <= ID_M0;
          end else if (gnt_m1) begin
            last_gnt <= ID_M1;
            // a single-beat limit never needs the locked state
            if (bus.m1_lock_i && (BURST_MAX > 1)) begin
              state     <= LOCK;
              burst_cnt <= CNT_W'(1);
            end else begin
              state     <= ARB;
            end
          end else begin
            last_gnt <= last_gnt;
          end
        end
        LOCK: begin
          if (gnt_m1 && bus.m1_lock_i) begin
            if (cnt_inc == CNT_W'(BURST_MAX)) begin
              // burst limit reached: hand the next contention to m0
              state     <= ARB;
              last_gnt  <= ID_M1;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= cnt_inc;
            end
          end else begin
            // request or lock dropped: burst ends, final beat may be granted
            state     <= ARB;
            burst_cnt <= '0;
            if (gnt_m1) begin
              last_gnt <= ID_M1;
            end else begin
              last_gnt <= last_gnt;
            end
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver applies hand-computed directed
// vectors and queues the grant/read-valid events it expects (tagged with the
// cycle they must appear in); a negedge monitor pops and compares every event
// the DUT presents, and also checks reset and idle outputs.
module tb_dmem_arbiter;

  localparam int ADDR_W = 9;
  localparam int K_RV0  = 0;
  localparam int K_RV1  = 1;
  localparam int K_GNT0 = 2;
  localparam int K_GNT1 = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic        clk     = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] mem [0:511];

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.RAM_DEPTH(512), .BURST_MAX(16)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to tag expectations
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model with the known words reloaded during reset
  always @(posedge clk) begin
    if (reset_i) begin
      mem[1] <= 32'hCAFE_0001;
      mem[2] <= 32'hBEEF_0002;
      mem[5] <= 32'hDEAD_BEEF;
    end else if (bus.ram_we_o) begin
      mem[bus.ram_addr_o] <= bus.ram_wdata_o;
    end
    bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  task automatic check_evt(input int kind, input logic [31:0] data);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event cyc=%0d: got kind=%0d data=%h, required no event",
               cyc, kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data || e.tag != cyc) begin
        n_fail++;
        $display("FAIL event cyc=%0d: got kind=%0d data=%h, required kind=%0d data=%h cyc=%0d",
                 cyc, kind, data, e.kind, e.data, e.tag);
      end
    end
  endtask

  // Monitor: compare every presented event against the scoreboard
  always @(negedge clk) begin
    if (reset_i) begin
      n_checks++;
      if (bus.m0_gnt_o || bus.m1_gnt_o || bus.m0_rvalid_o || bus.m1_rvalid_o ||
          bus.ram_we_o || bus.rdata_o != 32'h0 || bus.ram_addr_o != '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d: gnt=%b%b rv=%b%b we=%b rdata=%h addr=%h, required all 0",
                 cyc, bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o,
                 bus.ram_we_o, bus.rdata_o, bus.ram_addr_o);
      end
    end else begin
      n_checks++;
      if (bus.m0_gnt_o && bus.m1_gnt_o) begin
        n_fail++;
        $display("FAIL one_hot_gnt cyc=%0d: got both grants, required at most one", cyc);
      end
      if (!bus.m0_req_i && !bus.m1_req_i) begin
        n_checks++;
        if (bus.ram_we_o || bus.ram_addr_o != '0 || bus.ram_wdata_o != 32'h0) begin
          n_fail++;
          $display("FAIL idle_port cyc=%0d: got we=%b addr=%h wdata=%h, required 0/0/0",
                   cyc, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o);
        end
      end
      if (bus.m0_rvalid_o) check_evt(K_RV0, bus.rdata_o);
      if (bus.m1_rvalid_o) check_evt(K_RV1, bus.rdata_o);
      if (bus.m0_gnt_o)    check_evt(K_GNT0, 32'(bus.ram_addr_o));
      if (bus.m1_gnt_o)    check_evt(K_GNT1, 32'(bus.ram_addr_o));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.tag  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drive_m0(input logic req, input logic we, input int addr, input logic [31:0] wdata);
    bus.m0_req_i   = req;
    bus.m0_we_i    = we;
    bus.m0_addr_i  = addr[ADDR_W-1:0];
    bus.m0_wdata_i = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic lock, input int addr,
                          input logic [31:0] wdata);
    bus.m1_req_i   = req;
    bus.m1_we_i    = we;
    bus.m1_lock_i  = lock;
    bus.m1_addr_i  = addr[ADDR_W-1:0];
    bus.m1_wdata_i = wdata;
  endtask

  task automatic idle();
    drive_m0(1'b0, 1'b0, 0, 32'h0);
    drive_m1(1'b0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    idle();
    bus.ram_rdata_i = 32'h0;
    // reset with an active request: outputs must stay quiet
    drive_m0(1'b1, 1'b0, 7, 32'h0);
    repeat (3) step();
    reset_i = 1'b0;
    idle();
    step();

    // single m0 read of word 5
    step(); drive_m0(1'b1, 1'b0, 5, 32'h0); expect_evt(K_GNT0, 32'd5);
    step(); idle(); expect_evt(K_RV0, 32'hDEAD_BEEF);
    step();

    // fresh reset, then both write continuously: grants alternate m0,m1,...
    step(); reset_i = 1'b1;
    step(); reset_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      drive_m0(1'b1, 1'b1, 10 + (k + 1) / 2, 32'h0000_1000 + k);
      drive_m1(1'b1, 1'b1, 1'b0, 20 + k / 2, 32'h0000_2000 + k);
      if (k % 2 == 0) expect_evt(K_GNT0, 32'(10 + k / 2));
      else            expect_evt(K_GNT1, 32'(20 + k / 2));
    end
    step(); idle();

    // m1 locked 20-word write burst against a waiting m0
    step(); drive_m1(1'b1, 1'b1, 1'b1, 100, 32'h0); expect_evt(K_GNT1, 32'd100);
    for (int k = 1; k < 16; k++) begin
      step();
      drive_m0(1'b1, 1'b1, 50, 32'h5050_5050);
      drive_m1(1'b1, 1'b1, 1'b1, 100 + k, 32'(k));
      expect_evt(K_GNT1, 32'(100 + k));
    end
    step(); drive_m1(1'b1, 1'b1, 1'b1, 116, 32'd16); expect_evt(K_GNT0, 32'd50);
    for (int k = 16; k < 20; k++) begin
      step();
      drive_m0(1'b1, 1'b1, 51, 32'h5151_5151);
      drive_m1(1'b1, 1'b1, (k < 19) ? 1'b1 : 1'b0, 100 + k, 32'(k));
      expect_evt(K_GNT1, 32'(100 + k));
    end
    step(); drive_m1(1'b0, 1'b0, 1'b0, 0, 32'h0); expect_evt(K_GNT0, 32'd51);
    step(); idle();

    // interleaved and contending reads, back-to-back read-valids
    step(); drive_m0(1'b1, 1'b0, 1, 32'h0); expect_evt(K_GNT0, 32'd1);
    step(); drive_m0(1'b0, 1'b0, 0, 32'h0); drive_m1(1'b1, 1'b0, 1'b0, 2, 32'h0);
    expect_evt(K_RV0, 32'hCAFE_0001); expect_evt(K_GNT1, 32'd2);
    step(); drive_m0(1'b1, 1'b0, 5, 32'h0); drive_m1(1'b1, 1'b0, 1'b0, 1, 32'h0);
    expect_evt(K_RV1, 32'hBEEF_0002); expect_evt(K_GNT0, 32'd5);
    step(); drive_m0(1'b0, 1'b0, 0, 32'h0);
    expect_evt(K_RV0, 32'hDEAD_BEEF); expect_evt(K_GNT1, 32'd1);
    step(); idle(); expect_evt(K_RV1, 32'hCAFE_0001);
    step();

    // reset mid-LOCK with an m1 read in flight
    step(); drive_m1(1'b1, 1'b0, 1'b1, 2, 32'h0); expect_evt(K_GNT1, 32'd2);
    step(); drive_m1(1'b1, 1'b0, 1'b1, 5, 32'h0); drive_m0(1'b1, 1'b0, 1, 32'h0);
    expect_evt(K_RV1, 32'hBEEF_0002); expect_evt(K_GNT1, 32'd5);
    step(); reset_i = 1'b1;
    step(); reset_i = 1'b0; expect_evt(K_GNT0, 32'd1);
    step(); drive_m0(1'b0, 1'b0, 0, 32'h0); drive_m1(1'b1, 1'b0, 1'b0, 2, 32'h0);
    expect_evt(K_RV0, 32'hCAFE_0001); expect_evt(K_GNT1, 32'd2);
    step(); idle(); expect_evt(K_RV1, 32'hBEEF_0002);
    repeat (4) step();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d events never presented, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
